// File: rtl/fir_coef_ctrl_if.sv
// Config and sample channels between the FIR coefficient controller and its source.
// No latency of its own; it only bundles wires.
// Valid/ready on both channels; the source side (master) holds data until ready.
interface fir_coef_ctrl_if #(
  parameter int DATA_WIDTH  = 12,
  parameter int COEFF_WIDTH = 8
);
  logic                   cfg_valid;
  logic                   cfg_ready;
  logic [COEFF_WIDTH-1:0] cfg_data;
  logic                   cfg_last;
  logic                   smp_valid;
  logic                   smp_ready;
  logic [DATA_WIDTH-1:0]  smp_data;

  modport master (
    output cfg_valid, cfg_data, cfg_last, smp_valid, smp_data,
    input  cfg_ready, smp_ready
  );

  modport slave (
    input  cfg_valid, cfg_data, cfg_last, smp_valid, smp_data,
    output cfg_ready, smp_ready
  );
endinterface

// File: rtl/fir_coef_ctrl.sv
// Coefficient loader, delay-line flush sequencer and sample pacer for the symmetric FIR.
// Latency: sample -> fir_signal_o 1 cycle; out_valid_o follows FIR_LATENCY cycles later.
// Backpressure: cfg_ready low in COMMIT/FLUSH; smp_ready high only in RUN.
// Optional: define FIR_COEF_CTRL_UNDERRUN_CNT_EN to add the 16-bit underrun_cnt_o counter.
module fir_coef_ctrl #(
  parameter int DATA_WIDTH   = 12,
  parameter int COEFF_WIDTH  = 8,
  parameter int FLUSH_CYCLES = 12,
  parameter int FIR_LATENCY  = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  fir_coef_ctrl_if.slave         bus,
  output logic                   load_o,
  output logic [COEFF_WIDTH-1:0] coef0_o,
  output logic [COEFF_WIDTH-1:0] coef1_o,
  output logic [COEFF_WIDTH-1:0] coef2_o,
  output logic [COEFF_WIDTH-1:0] coef3_o,
  output logic [COEFF_WIDTH-1:0] coef4_o,
  output logic [COEFF_WIDTH-1:0] coef5_o,
  output logic [DATA_WIDTH-1:0]  fir_signal_o,
  output logic                   out_valid_o,
  output logic                   busy_o,
  output logic                   err_o
`ifdef FIR_COEF_CTRL_UNDERRUN_CNT_EN
  , output logic [15:0]          underrun_cnt_o
`endif
);

  typedef enum logic [2:0] {IDLE, LOAD, COMMIT, FLUSH, RUN} state_e;

  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [2:0]             idx_q, idx_d;
  // Only beats 0..4 need buffering; beat 5 goes straight into the committed bank.
  logic [COEFF_WIDTH-1:0] shadow_q [5];
  logic [COEFF_WIDTH-1:0] shadow_d [5];
  logic [COEFF_WIDTH-1:0] coef_q [6];
  logic [COEFF_WIDTH-1:0] coef_d [6];
  logic                   has_bank_q, has_bank_d;
  logic [CNT_W-1:0]       flush_cnt_q, flush_cnt_d;
  logic [DATA_WIDTH-1:0]  fir_q, fir_d;
  logic                   tag_q, tag_d;
  logic [FIR_LATENCY-1:0] vld_sr_q, vld_sr_d;
  logic                   err_q, err_d;

  logic cfg_rdy, smp_rdy, cfg_fire, smp_fire;

  assign cfg_rdy  = (state_q == IDLE) || (state_q == LOAD) || (state_q == RUN);
  assign smp_rdy  = (state_q == RUN);
  assign cfg_fire = bus.cfg_valid && cfg_rdy;
  assign smp_fire = bus.smp_valid && smp_rdy;

  // Ready is forced low while reset is held so no beat looks accepted during reset.
  assign bus.cfg_ready = rst_ni & cfg_rdy;
  assign bus.smp_ready = smp_rdy;

  // Next-state: FSM, beat capture/commit, flush counter, sample pacing and valid tracking.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    coef_d      = coef_q;
    has_bank_d  = has_bank_q;
    flush_cnt_d = flush_cnt_q;
    fir_d       = '0;
    tag_d       = 1'b0;
    err_d       = 1'b0;
    vld_sr_d    = vld_sr_q << 1;
    vld_sr_d[0] = tag_q;

    // Bubbles and non-RUN cycles push zeros with tag 0.
    if (smp_fire) begin
      fir_d = bus.smp_data;
      tag_d = 1'b1;
    end

    case (state_q)
      COMMIT: begin
        state_d     = FLUSH;
        flush_cnt_d = FLUSH_INIT;
        vld_sr_d    = '0;
      end
      FLUSH: begin
        if (flush_cnt_q == '0) state_d = RUN;
        else flush_cnt_d = flush_cnt_q - CNT_W'(1);
      end
      default: begin
        if (cfg_fire) begin
          if (bus.cfg_last && (idx_q == 3'd5)) begin
            // Bank becomes visible in the COMMIT cycle, alongside load_o.
            for (int i = 0; i < 5; i++) coef_d[i] = shadow_q[i];
            coef_d[5]  = bus.cfg_data;
            idx_d      = '0;
            has_bank_d = 1'b1;
            state_d    = COMMIT;
          end else if (bus.cfg_last || (idx_q == 3'd5)) begin
            err_d    = 1'b1;
            shadow_d = '{default: '0};
            idx_d    = '0;
            state_d  = has_bank_q ? RUN : IDLE;
          end else begin
            shadow_d[idx_q] = bus.cfg_data;
            idx_d           = idx_q + 3'd1;
            state_d         = LOAD;
          end
        end
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      shadow_q    <= '{default: '0};
      coef_q      <= '{default: '0};
      has_bank_q  <= 1'b0;
      flush_cnt_q <= '0;
      fir_q       <= '0;
      tag_q       <= 1'b0;
      vld_sr_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      coef_q      <= coef_d;
      has_bank_q  <= has_bank_d;
      flush_cnt_q <= flush_cnt_d;
      fir_q       <= fir_d;
      tag_q       <= tag_d;
      vld_sr_q    <= vld_sr_d;
      err_q       <= err_d;
    end
  end

`ifdef FIR_COEF_CTRL_UNDERRUN_CNT_EN
  logic [15:0] under_q, under_d;

  // Count RUN cycles with no sample offered, saturating; a commit restarts the count.
  always_comb begin
    under_d = under_q;
    if (state_q == COMMIT) under_d = '0;
    else if (smp_rdy && !bus.smp_valid && (under_q != 16'hFFFF)) under_d = under_q + 16'd1;
  end

  // Underrun counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) under_q <= '0;
    else         under_q <= under_d;
  end

  assign underrun_cnt_o = under_q;
`endif

  assign load_o       = (state_q == COMMIT);
  assign busy_o       = (state_q == LOAD) || (state_q == COMMIT) || (state_q == FLUSH);
  assign err_o        = err_q;
  assign fir_signal_o = fir_q;
  assign out_valid_o  = vld_sr_q[FIR_LATENCY-1];
  assign coef0_o      = coef_q[0];
  assign coef1_o      = coef_q[1];
  assign coef2_o      = coef_q[2];
  assign coef3_o      = coef_q[3];
  assign coef4_o      = coef_q[4];
  assign coef5_o      = coef_q[5];

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Directed bench for fir_coef_ctrl: reset, commit/flush, pacing, malformed bursts, async reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.
// Define FIR_COEF_CTRL_UNDERRUN_CNT_EN to also check the underrun counter.
module tb_fir_coef_ctrl;
  localparam int DW = 12;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fir_coef_ctrl_if #(.DATA_WIDTH(DW), .COEFF_WIDTH(CW)) bus ();

  logic          load, out_valid, busy, err;
  wire  [CW-1:0] coef [6];
  logic [DW-1:0] fir;
`ifdef FIR_COEF_CTRL_UNDERRUN_CNT_EN
  logic [15:0]   under;
`endif

  int checks = 0;
  int failures = 0;

  logic [CW-1:0] bank_a [6] = '{8'h05, 8'hFB, 8'h10, 8'h10, 8'hFB, 8'h05};
  logic [CW-1:0] bank_b [6] = '{8'h80, 8'h7F, 8'h01, 8'h02, 8'h03, 8'h04};

  fir_coef_ctrl #(.DATA_WIDTH(DW), .COEFF_WIDTH(CW), .FLUSH_CYCLES(12), .FIR_LATENCY(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus), .load_o(load),
    .coef0_o(coef[0]), .coef1_o(coef[1]), .coef2_o(coef[2]),
    .coef3_o(coef[3]), .coef4_o(coef[4]), .coef5_o(coef[5]),
    .fir_signal_o(fir), .out_valid_o(out_valid), .busy_o(busy), .err_o(err)
`ifdef FIR_COEF_CTRL_UNDERRUN_CNT_EN
    , .underrun_cnt_o(under)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus.cfg_valid = 1'b0; bus.cfg_data = '0; bus.cfg_last = 1'b0;
    bus.smp_valid = 1'b0; bus.smp_data = '0;
    rst_n = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    tick;
    checks++; if (fir !== '0) begin failures++; $display("FAIL reset_fir got=%0h exp=0", fir); end
    checks++; if (load !== 1'b0) begin failures++; $display("FAIL reset_load got=%0b exp=0", load); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", err); end
    checks++; if (bus.cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_cfg_ready got=%0b exp=1", bus.cfg_ready); end
    checks++; if (bus.smp_ready !== 1'b0) begin failures++; $display("FAIL reset_smp_ready got=%0b exp=0", bus.smp_ready); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (coef[i] !== '0) begin failures++; $display("FAIL reset_coef%0d got=%0h exp=0", i, coef[i]); end
    end
  endtask

  task automatic test_malformed_idle;
    // Single beat flagged last: too short.
    bus.cfg_valid = 1'b1; bus.cfg_data = 8'h03; bus.cfg_last = 1'b1;
    tick;
    bus.cfg_valid = 1'b0; bus.cfg_last = 1'b0;
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL idle_short_err got=%0b exp=1", err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_short_busy got=%0b exp=0", busy); end
    checks++; if (bus.smp_ready !== 1'b0) begin failures++; $display("FAIL idle_short_smp_ready got=%0b exp=0", bus.smp_ready); end
    tick;
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL idle_err_pulse got=%0b exp=0", err); end
    // Six beats with no last: sixth beat is malformed.
    for (int i = 0; i < 6; i++) begin
      bus.cfg_valid = 1'b1; bus.cfg_data = bank_b[i]; bus.cfg_last = 1'b0;
      tick;
      checks++; if (load !== 1'b0) begin failures++; $display("FAIL idle_nolast_load beat=%0d got=%0b exp=0", i, load); end
      checks++; if (err !== (i == 5)) begin failures++; $display("FAIL idle_nolast_err beat=%0d got=%0b exp=%0b", i, err, (i == 5)); end
    end
    bus.cfg_valid = 1'b0;
    checks++; if (bus.smp_ready !== 1'b0) begin failures++; $display("FAIL idle_nolast_smp_ready got=%0b exp=0", bus.smp_ready); end
    checks++; if (coef[1] !== '0) begin failures++; $display("FAIL idle_nolast_coef1 got=%0h exp=0", coef[1]); end
    tick;
  endtask

  task automatic test_commit;
    int loads;
    loads = 0;
    for (int i = 0; i < 6; i++) begin
      bus.cfg_valid = 1'b1; bus.cfg_data = bank_a[i]; bus.cfg_last = (i == 5);
      tick;
      if (load) loads++;
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL commit_busy beat=%0d got=%0b exp=1", i, busy); end
    end
    bus.cfg_valid = 1'b0; bus.cfg_last = 1'b0;
    checks++; if (load !== 1'b1) begin failures++; $display("FAIL commit_load got=%0b exp=1", load); end
    checks++; if (bus.cfg_ready !== 1'b0) begin failures++; $display("FAIL commit_cfg_ready got=%0b exp=0", bus.cfg_ready); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (coef[i] !== bank_a[i]) begin failures++; $display("FAIL commit_coef%0d got=%0h exp=%0h", i, coef[i], bank_a[i]); end
    end
    // A sample is offered throughout the flush and must not be taken.
    bus.smp_valid = 1'b1; bus.smp_data = 12'd77;
    for (int k = 0; k < 12; k++) begin
      tick;
      if (load) loads++;
      checks++; if (fir !== '0) begin failures++; $display("FAIL flush_fir cyc=%0d got=%0h exp=0", k, fir); end
      checks++; if (bus.smp_ready !== 1'b0) begin failures++; $display("FAIL flush_smp_ready cyc=%0d got=%0b exp=0", k, bus.smp_ready); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL flush_busy cyc=%0d got=%0b exp=1", k, busy); end
    end
    bus.smp_valid = 1'b0;
    tick;
    checks++; if (bus.smp_ready !== 1'b1) begin failures++; $display("FAIL run_smp_ready got=%0b exp=1", bus.smp_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL run_busy got=%0b exp=0", busy); end
    checks++; if (fir !== '0) begin failures++; $display("FAIL run_first_fir got=%0h exp=0", fir); end
    checks++; if (loads != 1) begin failures++; $display("FAIL commit_load_count got=%0d exp=1", loads); end
`ifdef FIR_COEF_CTRL_UNDERRUN_CNT_EN
    checks++; if (under !== 16'd0) begin failures++; $display("FAIL under_after_commit got=%0d exp=0", under); end
`endif
  endtask

  task automatic test_underrun;
    for (int i = 0; i < 7; i++) begin
      tick;
      checks++; if (fir !== '0) begin failures++; $display("FAIL bubble_fir cyc=%0d got=%0h exp=0", i, fir); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bubble_out_valid cyc=%0d got=%0b exp=0", i, out_valid); end
    end
`ifdef FIR_COEF_CTRL_UNDERRUN_CNT_EN
    checks++; if (under !== 16'd7) begin failures++; $display("FAIL under_seven got=%0d exp=7", under); end
`endif
  endtask

  task automatic test_run;
    logic [DW-1:0] d [9];
    logic          v [9];
    logic [DW-1:0] exp_fir;
    logic          exp_ov;
    d = '{12'd100, 12'hF38, 12'd300, 12'h5A5, 12'h5A5, 12'h5A5, 12'h5A5, 12'h5A5, 12'h5A5};
    v = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int j = 0; j < 9; j++) begin
      bus.smp_valid = v[j]; bus.smp_data = d[j];
      tick;
      exp_fir = v[j] ? d[j] : '0;
      exp_ov  = (j >= 4) && (j <= 6);
      checks++; if (fir !== exp_fir) begin failures++; $display("FAIL run_fir idx=%0d got=%0d exp=%0d", j, $signed(fir), $signed(exp_fir)); end
      checks++; if (out_valid !== exp_ov) begin failures++; $display("FAIL run_out_valid idx=%0d got=%0b exp=%0b", j, out_valid, exp_ov); end
    end
    bus.smp_valid = 1'b0;
`ifdef FIR_COEF_CTRL_UNDERRUN_CNT_EN
    checks++; if (under !== 16'd13) begin failures++; $display("FAIL under_run got=%0d exp=13", under); end
`endif
  endtask

  task automatic test_back_to_back_cfg_smp;
    // Beat and sample accepted together in RUN, then a short burst.
    bus.cfg_valid = 1'b1; bus.cfg_data = 8'h11; bus.cfg_last = 1'b0;
    bus.smp_valid = 1'b1; bus.smp_data = 12'd55;
    tick;
    checks++; if (fir !== 12'd55) begin failures++; $display("FAIL simul_fir got=%0d exp=55", fir); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL simul_busy got=%0b exp=1", busy); end
    checks++; if (bus.smp_ready !== 1'b0) begin failures++; $display("FAIL simul_smp_ready got=%0b exp=0", bus.smp_ready); end
    bus.smp_data = 12'd66;
    for (int i = 1; i < 4; i++) begin
      bus.cfg_data = 8'(8'h11 + i); bus.cfg_last = (i == 3);
      tick;
      checks++; if (load !== 1'b0) begin failures++; $display("FAIL short_load beat=%0d got=%0b exp=0", i, load); end
      checks++; if (err !== (i == 3)) begin failures++; $display("FAIL short_err beat=%0d got=%0b exp=%0b", i, err, (i == 3)); end
      if (i < 3) begin
        checks++; if (fir !== '0) begin failures++; $display("FAIL load_stall_fir beat=%0d got=%0d exp=0", i, fir); end
      end
    end
    bus.cfg_valid = 1'b0; bus.cfg_last = 1'b0;
    checks++; if (bus.smp_ready !== 1'b1) begin failures++; $display("FAIL short_back_to_run got=%0b exp=1", bus.smp_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL short_busy got=%0b exp=0", busy); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (coef[i] !== bank_a[i]) begin failures++; $display("FAIL short_coef%0d got=%0h exp=%0h", i, coef[i], bank_a[i]); end
    end
    tick;
    bus.smp_valid = 1'b0;
    checks++; if (fir !== 12'd66) begin failures++; $display("FAIL stalled_sample_fir got=%0d exp=66", fir); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL short_err_pulse got=%0b exp=0", err); end
  endtask

  task automatic test_recommit_reset;
    for (int i = 0; i < 6; i++) begin
      bus.cfg_valid = 1'b1; bus.cfg_data = bank_b[i]; bus.cfg_last = (i == 5);
      tick;
    end
    bus.cfg_valid = 1'b0; bus.cfg_last = 1'b0;
    checks++; if (load !== 1'b1) begin failures++; $display("FAIL recommit_load got=%0b exp=1", load); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (coef[i] !== bank_b[i]) begin failures++; $display("FAIL recommit_coef%0d got=%0h exp=%0h", i, coef[i], bank_b[i]); end
    end
    tick;
`ifdef FIR_COEF_CTRL_UNDERRUN_CNT_EN
    checks++; if (under !== 16'd0) begin failures++; $display("FAIL under_cleared got=%0d exp=0", under); end
`endif
    tick; tick;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (fir !== '0) begin failures++; $display("FAIL arst_fir got=%0h exp=0", fir); end
    checks++; if (load !== 1'b0) begin failures++; $display("FAIL arst_load got=%0b exp=0", load); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL arst_busy got=%0b exp=0", busy); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_out_valid got=%0b exp=0", out_valid); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL arst_err got=%0b exp=0", err); end
    checks++; if (bus.cfg_ready !== 1'b0) begin failures++; $display("FAIL arst_cfg_ready got=%0b exp=0", bus.cfg_ready); end
    checks++; if (bus.smp_ready !== 1'b0) begin failures++; $display("FAIL arst_smp_ready got=%0b exp=0", bus.smp_ready); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (coef[i] !== '0) begin failures++; $display("FAIL arst_coef%0d got=%0h exp=0", i, coef[i]); end
    end
`ifdef FIR_COEF_CTRL_UNDERRUN_CNT_EN
    checks++; if (under !== 16'd0) begin failures++; $display("FAIL arst_under got=%0d exp=0", under); end
`endif
    tick;
    rst_n = 1'b1;
    tick;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL post_rst_busy got=%0b exp=0", busy); end
    checks++; if (bus.cfg_ready !== 1'b1) begin failures++; $display("FAIL post_rst_cfg_ready got=%0b exp=1", bus.cfg_ready); end
    checks++; if (bus.smp_ready !== 1'b0) begin failures++; $display("FAIL post_rst_smp_ready got=%0b exp=0", bus.smp_ready); end
    checks++; if (load !== 1'b0) begin failures++; $display("FAIL post_rst_load got=%0b exp=0", load); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_malformed_idle;
    test_commit;
    test_underrun;
    test_run;
    test_back_to_back_cfg_smp;
    test_recommit_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fir_coef_ctrl.md
Name: fir_coef_ctrl

Overview:
- Control front-end for the symmetricFIR datapath.
- Accepts six coefficients serially over a valid/ready config channel into a shadow bank, then commits them atomically with a one-cycle load pulse.
- After each commit, flushes the filter delay line with zeros, then paces input samples into the filter and inserts zero bubbles when no sample is offered.
- Tracks which filter outputs derive from real samples and flags them with a valid bit.

Parameters:
- DATA_WIDTH, 12, sample width (signed).
- COEFF_WIDTH, 8, coefficient width (signed).
- FLUSH_CYCLES, 12, zero samples driven after each commit; minimum 1.
- FIR_LATENCY, 4, cycles from a sample on fir_signal_o to its result on the filter output; minimum 1.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- cfg_valid_i  in  1  coefficient beat valid.
- cfg_ready_o  out  1  coefficient beat accepted.
- cfg_data_i  in  COEFF_WIDTH  coefficient; beat order is coef0..coef5.
- cfg_last_i  in  1  marks the final (6th) beat.
- smp_valid_i  in  1  input sample valid.
- smp_ready_o  out  1  input sample accepted.
- smp_data_i  in  DATA_WIDTH  input sample.
- load_o  out  1  to filter load_i; one-cycle commit pulse.
- coef0_o..coef5_o  out  COEFF_WIDTH each  committed coefficients, to filter coef0_i..coef5_i.
- fir_signal_o  out  DATA_WIDTH  to filter signal_i.
- out_valid_o  out  1  filter output carries a real sample.
- busy_o  out  1  high in LOAD, COMMIT or FLUSH.
- err_o  out  1  one-cycle pulse on a malformed config burst.

Behaviour:
- Reset (async assert, sync deassert): state IDLE. All registered outputs are 0. Shadow bank, committed bank, beat index, flush counter and valid shift register are all cleared.
- States: IDLE, LOAD, COMMIT, FLUSH, RUN.
- cfg_ready_o = 1 in IDLE, LOAD and RUN; 0 in COMMIT and FLUSH.
- smp_ready_o = 1 only in RUN.
- Beat accept: a beat is accepted when cfg_valid_i && cfg_ready_o.
  - The beat is written to shadow[idx], then idx increments.
  - The first beat in IDLE or RUN moves the FSM to LOAD, with idx starting at 0.
- LOAD → COMMIT: on the beat with idx=5 and cfg_last_i=1.
- Malformed burst (cfg_last_i=1 with idx<5, or idx=5 with cfg_last_i=0):
  - err_o pulses one cycle, the shadow bank is discarded and idx is cleared.
  - The FSM returns to RUN if a bank has been committed since reset, otherwise to IDLE.
  - The committed bank is unchanged.
- COMMIT (one cycle):
  - The committed bank is updated from the shadow bank.
  - load_o=1 in this same cycle, and coef*_o present the new values while load_o is high.
  - Next state is FLUSH with the flush counter set to FLUSH_CYCLES-1.
- FLUSH: fir_signal_o=0; the counter decrements each cycle; go to RUN when the counter reaches 0. Exactly FLUSH_CYCLES zero cycles are driven.
- RUN: fir_signal_o is registered each cycle.
  - smp_data_i on a handshake, with tag=1.
  - 0 on a bubble, with tag=0.
- LOAD and IDLE: fir_signal_o=0, tag=0. Samples stall in LOAD.
- Valid tracking: the tag enters a FIR_LATENCY-deep shift register in the cycle fir_signal_o takes the value. out_valid_o is the tail of that register, so it rises exactly FIR_LATENCY cycles after the tagged sample appears.
  - COMMIT clears the whole shift register synchronously.
- Simultaneous events: in RUN, a cfg beat and a sample handshake in the same cycle are both accepted; the FSM enters LOAD next cycle.
- coef*_o change only in COMMIT; they hold their values through LOAD.
- Reset mid-LOAD or mid-FLUSH: everything is cleared immediately, with no load_o pulse.

Optional Feature:
- Macro: FIR_COEF_CTRL_UNDERRUN_CNT_EN
- When defined:
  - Adds port underrun_cnt_o, out, 16 bits, reset 0.
  - Increments on every RUN cycle with smp_valid_i=0 and saturates at 0xFFFF.
  - Cleared in COMMIT.
- When undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then burst 0x05,0xFB,0x10,0x10,0xFB,0x05 with last on beat 6 → load_o high for exactly one cycle. In that cycle coef0_o..coef5_o = 5,-5,16,16,-5,5. busy_o=1 from the first beat until 12 flush cycles end.
- After commit → fir_signal_o=0 for exactly 12 cycles, smp_ready_o=0 during that time, then smp_ready_o=1.
- RUN: samples 100,-200,300 back-to-back, then smp_valid_i low for 2 cycles → fir_signal_o shows 100,-200,300,0,0. out_valid_o pattern is 1,1,1,0,0, starting 4 cycles after the 100.
- Burst of 4 beats with last on beat 4 → err_o pulses one cycle, no load_o, coef*_o still 5,-5,16,16,-5,5, FSM back in RUN.
- Assert rst_ni low mid-FLUSH → all outputs 0 asynchronously. After release, state is IDLE, smp_ready_o=0, cfg_ready_o=1.
- With FIR_COEF_CTRL_UNDERRUN_CNT_EN defined: 7 idle RUN cycles → underrun_cnt_o=7. A new commit returns it to 0.
